// File: rtl/ne_fp_pkg.sv
// Shared constants and types for the fp exponent-align issue path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ne_fp_pkg;

  localparam logic [3:0] OPM_FP4  = 4'b1000;
  localparam logic [3:0] OPM_FP16 = 4'b0100;
  localparam logic [3:0] OPM_FP8  = 4'b0010;

  localparam int A_EW  = 9;
  localparam int B_EW  = 6;
  localparam int LANES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One entry of the tag pipe that shadows the align datapath.
  typedef struct packed {
    logic       vld;
    logic       last;
    logic [3:0] mode;
  } tag_t;

  // Only the three one-hot mode codes are meaningful to the datapath.
  function automatic logic opm_legal(input logic [3:0] m);
    return (m == OPM_FP4) || (m == OPM_FP16) || (m == OPM_FP8);
  endfunction

endpackage

// File: rtl/ne_fp_credit_cnt.sv
// Downstream credit counter: up on return, down on issue, saturates at CREDITS.
// Latency: count updates one cycle after inc/dec.
// Backpressure: none; the owner gates dec with cnt!=0.
module ne_fp_credit_cnt #(
  parameter int CREDITS = 4,
  parameter int CW      = 3,
  parameter bit CHK     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt
);

  logic ovf;

  // A return with every slot already free means the downstream miscounted.
  assign ovf = inc && !dec && (cnt == CW'(CREDITS));

  // Simultaneous inc and dec cancel; an overflowing return is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CW'(CREDITS);
    end else if (dec && !inc) begin
      cnt <= cnt - CW'(1);
    end else if (inc && !dec && !ovf) begin
      cnt <= cnt + CW'(1);
    end
  end

  if (CHK) begin : g_chk
    // Flag a credit return that would push the count past CREDITS.
    a_no_ovf : assert property (@(posedge clk) disable iff (!rst_n) !ovf);
  end

endmodule

// File: rtl/ne_fp_ffp_e_align_seq.sv
// Issue sequencer for the 16-lane exponent-align datapath, tags its results.
// Latency: issue is combinational; out_* tags follow an issue by DP_LAT cycles.
// Backpressure: in_rdy low in IDLE/DRAIN, with no credits, or on a pending mode change.
module ne_fp_ffp_e_align_seq
  import ne_fp_pkg::*;
#(
  parameter int DP_LAT     = 2,
  parameter int CREDITS    = 4,
  parameter int CW         = 3,
  parameter bit CREDIT_CHK = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [3:0]               in_op_mode,
  input  logic [LANES*A_EW-1:0]    in_a_e,
  input  logic [LANES*B_EW-1:0]    in_b_e,
  input  logic                     in_last,
  output logic [3:0]               dp_op_mode,
  output logic [LANES*A_EW-1:0]    dp_a_e,
  output logic [LANES*B_EW-1:0]    dp_b_e,
  output logic                     out_vld,
  output logic                     out_last,
  output logic [3:0]               out_op_mode,
  input  logic                     credit_ret,
  output logic                     busy,
  output logic                     err_illegal
);

  localparam int IW = $clog2(DP_LAT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cur_mode;
  tag_t          tag_pipe [DP_LAT];
  logic [IW-1:0] inflight;
  logic [CW-1:0] credits;
  logic          legal;
  logic          mode_chg;
  logic          accept;
  logic          issue;

  // Count vectors still travelling through the datapath.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DP_LAT; i++) begin
      inflight = inflight + IW'(tag_pipe[i].vld);
    end
  end

  // A mode change only matters inside a group; an open group has cur_mode!=0.
  assign legal    = opm_legal(in_op_mode);
  assign mode_chg = in_vld && (in_op_mode != cur_mode) && (cur_mode != 4'b0000);
  assign accept   = in_vld && in_rdy;
  assign issue    = accept && legal;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE spends one cycle noticing traffic, DRAIN empties the pipe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_vld) state_nxt = RUN;
      end
      RUN: begin
        if (issue && in_last) begin
          state_nxt = IDLE;
        end else if (mode_chg && (inflight != '0)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: accept only in RUN with a free slot and no mode clash in flight.
  always_comb begin
    in_rdy = 1'b0;
    if (state == RUN) begin
      in_rdy = (credits != '0) && !(mode_chg && (inflight != '0));
    end
  end

  // Datapath feed is zero whenever nothing is issued so it never sees stale lanes.
  always_comb begin
    dp_op_mode = '0;
    dp_a_e     = '0;
    dp_b_e     = '0;
    if (issue) begin
      dp_op_mode = in_op_mode;
      dp_a_e     = in_a_e;
      dp_b_e     = in_b_e;
    end
  end

  // Track the open group's mode; closing the group forgets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mode <= '0;
    end else if (issue) begin
      cur_mode <= in_last ? 4'b0000 : in_op_mode;
    end
  end

  // Tag pipe mirrors the datapath depth; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0].vld  <= issue;
      tag_pipe[0].last <= issue && in_last;
      tag_pipe[0].mode <= issue ? in_op_mode : 4'b0000;
      for (int i = 1; i < DP_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Illegal vectors are swallowed but remembered until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (accept && !legal) begin
      err_illegal <= 1'b1;
    end
  end

  assign out_vld     = tag_pipe[DP_LAT-1].vld;
  assign out_last    = tag_pipe[DP_LAT-1].last;
  assign out_op_mode = tag_pipe[DP_LAT-1].mode;
  assign busy        = (state != IDLE) || (inflight != '0);

  ne_fp_credit_cnt #(
    .CREDITS (CREDITS),
    .CW      (CW),
    .CHK     (CREDIT_CHK)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (credit_ret),
    .dec   (issue),
    .cnt   (credits)
  );

endmodule
